alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 33 +++
 rtl/alu_sequencer_alu.sv | 38 +++
 rtl/alu_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: instruction field layout, opcodes,
// funct codes and register indices.
package alu_sequencer_pkg;

    localparam int unsigned NUM_REGS = 4;

    localparam int unsigned RD_MSB    = 7;
    localparam int unsigned RD_LSB    = 6;
    localparam int unsigned RS1_MSB   = 5;
    localparam int unsigned RS1_LSB   = 4;
    localparam int unsigned FUNCT_MSB = 3;
    localparam int unsigned FUNCT_LSB = 2;
    localparam int unsigned IMM_BIT   = 1;
    localparam int unsigned OP_BIT    = 0;

    localparam logic OP_R = 1'b0;

    localparam logic [1:0] R_ADD = 2'b00;
    localparam logic [1:0] R_AND = 2'b01;
    localparam logic [1:0] R_OR  = 2'b10;

    localparam logic [1:0] REG0 = 2'd0;
    localparam logic [1:0] REG1 = 2'd1;
    localparam logic [1:0] REG2 = 2'd2;
    localparam logic [1:0] REG3 = 2'd3;

    // Builds a register-register instruction with the imm flag clear.
    function automatic logic [7:0] encode_r(input logic [1:0] rd, input logic [1:0] rs1,
                                            input logic [1:0] funct);
        return {rd, rs1, funct, 1'b0, OP_R};
    endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU: decodes the latched instruction and computes rd_val op rs1_val,
// flagging anything that is not a supported R-type operation as illegal.
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned IW = 8
) (
    input  logic [IW-1:0] instr,
    input  logic [DW-1:0] rd_val,
    input  logic [DW-1:0] rs1_val,
    output logic [DW-1:0] y,
    output logic          illegal
);

    logic [1:0] funct;
    assign funct = instr[FUNCT_MSB:FUNCT_LSB];

    // Register indices are resolved by the sequencer; the ALU only needs the opcode fields.
    logic unused_fields;
    assign unused_fields = ^instr[IW-1:FUNCT_MSB+1];

    always_comb begin
        y       = '0;
        illegal = 1'b0;
        if (instr[OP_BIT] != OP_R || instr[IMM_BIT]) begin
            illegal = 1'b1;
        end else begin
            unique case (funct)
                R_ADD:   y = rd_val + rs1_val;
                R_AND:   y = rd_val & rs1_val;
                R_OR:    y = rd_val | rs1_val;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer around a small register file and ALU:
// IDLE accepts an instruction, DECODE reads operands, EXEC computes, WB retires.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned IW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [IW-1:0] instr,
    output logic          instr_ready,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] result,
    output logic          busy,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDecode = 2'd1,
        StExec   = 2'd2,
        StWb     = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] instr_q;
    logic [DW-1:0] rd_val_q, rs1_val_q, result_q;
    logic [DW-1:0] regs_q [NUM_REGS];
    logic [DW-1:0] alu_y;
    logic          alu_illegal;
    logic [1:0]    rd_idx, rs1_idx;

    assign rd_idx  = instr_q[RD_MSB:RD_LSB];
    assign rs1_idx = instr_q[RS1_MSB:RS1_LSB];

    alu_sequencer_alu #(
        .DW (DW),
        .IW (IW)
    ) u_alu (
        .instr   (instr_q),
        .rd_val  (rd_val_q),
        .rs1_val (rs1_val_q),
        .y       (alu_y),
        .illegal (alu_illegal)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (instr_valid) state_d = StDecode;
            StDecode: state_d = StExec;
            StExec:   state_d = StWb;
            StWb:     state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            rd_val_q  <= '0;
            rs1_val_q <= '0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && instr_valid) begin
                instr_q <= instr;
            end
            if (state_q == StDecode) begin
                rd_val_q  <= regs_q[rd_idx];
                rs1_val_q <= regs_q[rs1_idx];
            end
            // Illegal instructions leave the previous result visible.
            if (state_q == StExec && !alu_illegal) begin
                result_q <= alu_y;
            end
        end
    end

    // Preload and writeback live in different states, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == StIdle && cfg_we) begin
            regs_q[cfg_addr] <= cfg_wdata;
        end else if (state_q == StWb && !alu_illegal) begin
            regs_q[rd_idx] <= result_q;
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StWb) && !alu_illegal;
    assign err         = (state_q == StWb) && alu_illegal;
    assign result      = result_q;
    assign dbg_data    = regs_q[dbg_sel];

endmodule
